lieat_axi_arb: RTL and testbench
================================

LIEAT_AXI_ARB -- requirements
Module: lieat_axi_arb

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of client ports (2..8).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width; strobe width is DW/8.
REQ-004 SHALL have parameter IDW, default 4: AXI ID width, with IDW >= clog2(NPORT).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have client read ports c_arvalid/c_arready (input/output, NPORT); c_araddr (input, NPORT*AW); c_arlen (input, NPORT*8); c_arsize (input, NPORT*3).
REQ-008 SHALL have client read-data ports c_rvalid (output, NPORT); c_rready (input, NPORT); c_rdata (output, DW, shared); c_rlast (output, 1); c_rresp (output, 2).
REQ-009 SHALL have client write ports c_awvalid/c_awready (NPORT); c_awaddr (NPORT*AW); c_awlen (NPORT*8); c_awsize (NPORT*3); c_wvalid/c_wready (NPORT); c_wdata (NPORT*DW); c_wstrb (NPORT*DW/8); c_bvalid/c_bready (NPORT); c_bresp (output, 2, shared).
REQ-010 SHALL have io_master_* AXI4 master ports for AW, W, B, AR and R channels at widths AW/DW/IDW, with awburst/arburst fixed at 2'b01 (INCR).

Function
REQ-011 Read and write paths SHALL be independent FSMs and SHALL be able to run concurrently.
REQ-012 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA.
REQ-013 Read transitions: R_IDLE->R_ADDR when any c_arvalid is high (grant latched); R_ADDR->R_DATA on io_master_arready && arvalid; R_DATA->R_IDLE on rvalid && rready && rlast.
REQ-014 Arbitration SHALL be round-robin, one pointer per path: the lowest index at or after ptr+1 (mod NPORT) wins, and ptr is set to the winner when the grant latches.
REQ-015 Grant latency SHALL be one cycle: io_master_arvalid rises the cycle after the R_IDLE grant decision.
REQ-016 io_master_ar* SHALL be driven from registered copies of the granted port's signals, and arid SHALL equal the granted index zero-extended to IDW.
REQ-017 c_arready[g] SHALL pulse for exactly one cycle, in the R_ADDR handshake cycle.
REQ-018 In R_DATA: c_rvalid[g] = io_master_rvalid, io_master_rready = c_rready[g], and all other c_rvalid bits SHALL be 0.
REQ-019 An rid mismatch SHALL be forwarded with c_rresp forced to 2'b10 (SLVERR).
REQ-020 Write FSM states SHALL be W_IDLE, W_ADDR, W_DATA and W_RESP.
REQ-021 Write transitions: W_ADDR->W_DATA on the AW handshake; W_DATA->W_RESP on a W handshake where the beat counter equals awlen; W_RESP->W_IDLE on the B handshake.
REQ-022 The beat counter SHALL be 8 bits, SHALL clear at AW accept, and SHALL increment per W handshake.
REQ-023 io_master_wlast SHALL be 1 exactly when counter == latched awlen; awlen=0 SHALL give a single beat with wlast=1.
REQ-024 In W_DATA: wdata/wstrb/wvalid SHALL be passed through from port g, and c_wready[g] = io_master_wready.
REQ-025 B SHALL be routed to port g only, and bid == g SHALL be checked, else c_bresp SHALL be forced to 2'b10.
REQ-026 Non-granted ports SHALL see ready=0 and valid=0 on all channels.
REQ-027 A client deasserting arvalid/awvalid after grant SHALL NOT abort: the request was latched.
REQ-028 Only one outstanding transaction per path SHALL be allowed; new requests wait in IDLE.

Reset
REQ-029 On rstn low, asynchronously: FSMs SHALL go to IDLE, both pointers to NPORT-1 (so port 0 wins first), counter to 0, and all io_master valid/ready and c_* valid/ready outputs to 0.
REQ-030 Reset asserted mid-burst SHALL abandon the transaction; no recovery of the interrupted transfer is required.
REQ-031 After rstn rises, the first grant decision SHALL occur on the first clk edge with a request present.

Verification
REQ-032 Single read: port0 arvalid, araddr=0x8000_0000, arlen=0 -> io arvalid 1 cycle later, arid=0; one R beat with rlast=1 routed to c_rvalid[0] only; FSM back in R_IDLE.
REQ-033 Fairness: ports 0 and 1 requesting continuously with 4 reads each -> grants alternate 0,1,0,1...; neither port is granted twice in a row.
REQ-034 Burst write: port1 awlen=3, DW=32 -> four W beats, wlast only on the 4th, awid=1, B routed to port 1.
REQ-035 Concurrency: port0 read and port1 write issued in the same cycle -> io arvalid and awvalid both asserted the next cycle, and both complete.
REQ-036 Error paths: rid=3 returned for a grant-0 read -> c_rresp=2'b10; rstn pulsed low during W_DATA -> all valids 0 immediately and FSM in W_IDLE.
REQ-037 NPORT=4 build: ports 1 and 3 requesting with ptr=1 -> port 3 wins, then port 1.

Source files
------------

// File: rtl/lieat_axi_arb.sv
// lieat_axi_arb: NPORT-client to single AXI4 master arbiter.
// Read and write paths are independent round-robin arbiters, each with one
// transaction in flight. A grant latches the winning client's address
// request; the master-side AR/AW are driven from those registered copies,
// with the AXI ID carrying the granted port index.
// Ports:
//   clk, rstn          - clock (rising edge), async active-low reset
//   c_ar*/c_r*         - per-client read address / shared read data
//   c_aw*/c_w*/c_b*    - per-client write address, data, response
//   io_master_*        - AXI4 master AW/W/B/AR/R channels (INCR bursts)
module lieat_axi_arb #(
   parameter int NPORT = 2,
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int IDW   = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   // client read address / data
   input  logic [NPORT-1:0]      c_arvalid,
   output logic [NPORT-1:0]      c_arready,
   input  logic [NPORT*AW-1:0]   c_araddr,
   input  logic [NPORT*8-1:0]    c_arlen,
   input  logic [NPORT*3-1:0]    c_arsize,
   output logic [NPORT-1:0]      c_rvalid,
   input  logic [NPORT-1:0]      c_rready,
   output logic [DW-1:0]         c_rdata,
   output logic                  c_rlast,
   output logic [1:0]            c_rresp,
   // client write address / data / response
   input  logic [NPORT-1:0]      c_awvalid,
   output logic [NPORT-1:0]      c_awready,
   input  logic [NPORT*AW-1:0]   c_awaddr,
   input  logic [NPORT*8-1:0]    c_awlen,
   input  logic [NPORT*3-1:0]    c_awsize,
   input  logic [NPORT-1:0]      c_wvalid,
   output logic [NPORT-1:0]      c_wready,
   input  logic [NPORT*DW-1:0]   c_wdata,
   input  logic [NPORT*DW/8-1:0] c_wstrb,
   output logic [NPORT-1:0]      c_bvalid,
   input  logic [NPORT-1:0]      c_bready,
   output logic [1:0]            c_bresp,
   // master AW
   output logic                  io_master_awvalid,
   input  logic                  io_master_awready,
   output logic [AW-1:0]         io_master_awaddr,
   output logic [7:0]            io_master_awlen,
   output logic [2:0]            io_master_awsize,
   output logic [1:0]            io_master_awburst,
   output logic [IDW-1:0]        io_master_awid,
   // master W
   output logic                  io_master_wvalid,
   input  logic                  io_master_wready,
   output logic [DW-1:0]         io_master_wdata,
   output logic [DW/8-1:0]       io_master_wstrb,
   output logic                  io_master_wlast,
   // master B
   input  logic                  io_master_bvalid,
   output logic                  io_master_bready,
   input  logic [1:0]            io_master_bresp,
   input  logic [IDW-1:0]        io_master_bid,
   // master AR
   output logic                  io_master_arvalid,
   input  logic                  io_master_arready,
   output logic [AW-1:0]         io_master_araddr,
   output logic [7:0]            io_master_arlen,
   output logic [2:0]            io_master_arsize,
   output logic [1:0]            io_master_arburst,
   output logic [IDW-1:0]        io_master_arid,
   // master R
   input  logic                  io_master_rvalid,
   output logic                  io_master_rready,
   input  logic [DW-1:0]         io_master_rdata,
   input  logic [1:0]            io_master_rresp,
   input  logic                  io_master_rlast,
   input  logic [IDW-1:0]        io_master_rid
);

   localparam int PW = $clog2(NPORT);
   localparam int SW = DW / 8;
   localparam logic [PW-1:0] PTR_RST = PW'(NPORT - 1);
   localparam logic [1:0] SLVERR = 2'b10;

   // Round-robin pick: first requester at or after ptr+1, wrapping.
   function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                             input logic [PW-1:0]    ptr);
      logic [PW-1:0] win;
      logic          found;
      int            idx;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= NPORT; i++) begin
         idx = (int'(ptr) + i) % NPORT;
         if (!found && req[idx]) begin
            win   = PW'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   // ------------------------------------------------------------ read path
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

   rstate_e       rstate_q, rstate_d;
   logic [PW-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d, rwin;
   logic [AW-1:0] araddr_q, araddr_d;
   logic [7:0]    arlen_q, arlen_d;
   logic [2:0]    arsize_q, arsize_d;

   assign rwin = rr_pick(c_arvalid, rptr_q);

   always_comb begin
      rstate_d          = rstate_q;
      rgnt_d            = rgnt_q;
      rptr_d            = rptr_q;
      araddr_d          = araddr_q;
      arlen_d           = arlen_q;
      arsize_d          = arsize_q;
      io_master_arvalid = 1'b0;
      io_master_rready  = 1'b0;
      c_arready         = '0;
      c_rvalid          = '0;
      case (rstate_q)
         R_IDLE: begin
            // Request is captured here, so a client dropping arvalid
            // afterwards does not abort the transaction.
            if (|c_arvalid) begin
               rgnt_d   = rwin;
               rptr_d   = rwin;
               araddr_d = c_araddr[rwin*AW +: AW];
               arlen_d  = c_arlen[rwin*8 +: 8];
               arsize_d = c_arsize[rwin*3 +: 3];
               rstate_d = R_ADDR;
            end
         end
         R_ADDR: begin
            io_master_arvalid = 1'b1;
            if (io_master_arready) begin
               c_arready[rgnt_q] = 1'b1;
               rstate_d          = R_DATA;
            end
         end
         R_DATA: begin
            c_rvalid[rgnt_q] = io_master_rvalid;
            io_master_rready = c_rready[rgnt_q];
            if (io_master_rvalid && c_rready[rgnt_q] && io_master_rlast)
               rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rstate_q <= R_IDLE;
         rgnt_q   <= '0;
         rptr_q   <= PTR_RST;
         araddr_q <= '0;
         arlen_q  <= '0;
         arsize_q <= '0;
      end else begin
         rstate_q <= rstate_d;
         rgnt_q   <= rgnt_d;
         rptr_q   <= rptr_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
         arsize_q <= arsize_d;
      end
   end

   assign io_master_araddr  = araddr_q;
   assign io_master_arlen   = arlen_q;
   assign io_master_arsize  = arsize_q;
   assign io_master_arburst = 2'b01;
   assign io_master_arid    = IDW'(rgnt_q);

   // Data is shared; only the granted port's rvalid qualifies it. A beat
   // tagged with a foreign ID is still delivered but flagged as SLVERR.
   assign c_rdata = io_master_rdata;
   assign c_rlast = io_master_rlast;
   assign c_rresp = (io_master_rid != IDW'(rgnt_q)) ? SLVERR : io_master_rresp;

   // ----------------------------------------------------------- write path
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

   wstate_e       wstate_q, wstate_d;
   logic [PW-1:0] wgnt_q, wgnt_d, wptr_q, wptr_d, wwin;
   logic [AW-1:0] awaddr_q, awaddr_d;
   logic [7:0]    awlen_q, awlen_d;
   logic [2:0]    awsize_q, awsize_d;
   logic [7:0]    wcnt_q, wcnt_d;

   assign wwin = rr_pick(c_awvalid, wptr_q);

   always_comb begin
      wstate_d          = wstate_q;
      wgnt_d            = wgnt_q;
      wptr_d            = wptr_q;
      awaddr_d          = awaddr_q;
      awlen_d           = awlen_q;
      awsize_d          = awsize_q;
      wcnt_d            = wcnt_q;
      io_master_awvalid = 1'b0;
      io_master_wvalid  = 1'b0;
      io_master_bready  = 1'b0;
      c_awready         = '0;
      c_wready          = '0;
      c_bvalid          = '0;
      case (wstate_q)
         W_IDLE: begin
            if (|c_awvalid) begin
               wgnt_d   = wwin;
               wptr_d   = wwin;
               awaddr_d = c_awaddr[wwin*AW +: AW];
               awlen_d  = c_awlen[wwin*8 +: 8];
               awsize_d = c_awsize[wwin*3 +: 3];
               wstate_d = W_ADDR;
            end
         end
         W_ADDR: begin
            io_master_awvalid = 1'b1;
            if (io_master_awready) begin
               c_awready[wgnt_q] = 1'b1;
               wcnt_d            = '0;
               wstate_d          = W_DATA;
            end
         end
         W_DATA: begin
            io_master_wvalid = c_wvalid[wgnt_q];
            c_wready[wgnt_q] = io_master_wready;
            if (c_wvalid[wgnt_q] && io_master_wready) begin
               wcnt_d = wcnt_q + 8'd1;
               if (wcnt_q == awlen_q) wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            c_bvalid[wgnt_q] = io_master_bvalid;
            io_master_bready = c_bready[wgnt_q];
            if (io_master_bvalid && c_bready[wgnt_q]) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wstate_q <= W_IDLE;
         wgnt_q   <= '0;
         wptr_q   <= PTR_RST;
         awaddr_q <= '0;
         awlen_q  <= '0;
         awsize_q <= '0;
         wcnt_q   <= '0;
      end else begin
         wstate_q <= wstate_d;
         wgnt_q   <= wgnt_d;
         wptr_q   <= wptr_d;
         awaddr_q <= awaddr_d;
         awlen_q  <= awlen_d;
         awsize_q <= awsize_d;
         wcnt_q   <= wcnt_d;
      end
   end

   assign io_master_awaddr  = awaddr_q;
   assign io_master_awlen   = awlen_q;
   assign io_master_awsize  = awsize_q;
   assign io_master_awburst = 2'b01;
   assign io_master_awid    = IDW'(wgnt_q);

   // W payload always follows the granted port; wvalid gates its use.
   assign io_master_wdata = c_wdata[wgnt_q*DW +: DW];
   assign io_master_wstrb = c_wstrb[wgnt_q*SW +: SW];
   assign io_master_wlast = (wcnt_q == awlen_q);

   assign c_bresp = (io_master_bid != IDW'(wgnt_q)) ? SLVERR : io_master_bresp;

endmodule

// File: tb/tb_lieat_axi_arb.sv
// tb_lieat_axi_arb: directed bench for lieat_axi_arb built with NPORT=4.
// Inputs change 2 time units after the rising edge; outputs are sampled
// 1 unit later, well away from the next active edge.
module tb_lieat_axi_arb;
   localparam int NP = 4;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [NP-1:0]    c_arvalid, c_arready, c_rvalid, c_rready;
   logic [NP*32-1:0] c_araddr, c_awaddr, c_wdata;
   logic [NP*8-1:0]  c_arlen, c_awlen;
   logic [NP*3-1:0]  c_arsize, c_awsize;
   logic [31:0]      c_rdata;
   logic             c_rlast;
   logic [1:0]       c_rresp, c_bresp;
   logic [NP-1:0]    c_awvalid, c_awready, c_wvalid, c_wready, c_bvalid, c_bready;
   logic [NP*4-1:0]  c_wstrb;
   logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic             arvalid, arready, rvalid, rready, rlast;
   logic [31:0]      awaddr, araddr, wdata, rdata;
   logic [7:0]       awlen, arlen;
   logic [2:0]       awsize, arsize;
   logic [1:0]       awburst, arburst, bresp, rresp;
   logic [3:0]       awid, arid, bid, rid, wstrb;

   int total = 0;
   int bad   = 0;

   lieat_axi_arb #(.NPORT(NP), .AW(32), .DW(32), .IDW(4)) dut (
      .clk(clk), .rstn(rstn),
      .c_arvalid(c_arvalid), .c_arready(c_arready), .c_araddr(c_araddr),
      .c_arlen(c_arlen), .c_arsize(c_arsize),
      .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata),
      .c_rlast(c_rlast), .c_rresp(c_rresp),
      .c_awvalid(c_awvalid), .c_awready(c_awready), .c_awaddr(c_awaddr),
      .c_awlen(c_awlen), .c_awsize(c_awsize),
      .c_wvalid(c_wvalid), .c_wready(c_wready), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
      .c_bvalid(c_bvalid), .c_bready(c_bready), .c_bresp(c_bresp),
      .io_master_awvalid(awvalid), .io_master_awready(awready),
      .io_master_awaddr(awaddr), .io_master_awlen(awlen), .io_master_awsize(awsize),
      .io_master_awburst(awburst), .io_master_awid(awid),
      .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
      .io_master_wstrb(wstrb), .io_master_wlast(wlast),
      .io_master_bvalid(bvalid), .io_master_bready(bready),
      .io_master_bresp(bresp), .io_master_bid(bid),
      .io_master_arvalid(arvalid), .io_master_arready(arready),
      .io_master_araddr(araddr), .io_master_arlen(arlen), .io_master_arsize(arsize),
      .io_master_arburst(arburst), .io_master_arid(arid),
      .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
      .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int cnt0, cnt1, exp_g;
      rstn = 1'b0;
      c_arvalid = '0; c_araddr = '0; c_arlen = '0; c_arsize = '0; c_rready = '0;
      c_awvalid = '0; c_awaddr = '0; c_awlen = '0; c_awsize = '0;
      c_wvalid = '0; c_wdata = '0; c_wstrb = '0; c_bready = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;

      // reset state
      #12;
      chk("rst_arvalid", arvalid, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_bready", bready, 0);
      chk("rst_c_ready", {c_arready, c_awready, c_wready}, 0);
      chk("rst_c_valid", {c_rvalid, c_bvalid}, 0);
      @(posedge clk); #2;
      rstn = 1'b1;

      // single read, port 0
      c_arvalid = 4'b0001; c_araddr[31:0] = 32'h8000_0000; c_arlen[7:0] = 0; c_arsize[2:0] = 3'd2;
      #1 chk("rd1_no_early_arvalid", arvalid, 0);
      nxt();
      chk("rd1_arvalid", arvalid, 1);
      chk("rd1_arid", arid, 0);
      chk("rd1_araddr", araddr, 32'h8000_0000);
      chk("rd1_arlen_size_burst", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'b01});
      arready = 1;
      #1 chk("rd1_c_arready", c_arready, 4'b0001);
      nxt();
      arready = 0; c_arvalid = '0;
      rvalid = 1; rdata = 32'hDEAD_BEEF; rlast = 1; rid = 0; rresp = 0; c_rready = 4'b0001;
      #1 chk("rd1_arvalid_done", arvalid, 0);
      chk("rd1_c_arready_pulse", c_arready, 0);
      chk("rd1_c_rvalid", c_rvalid, 4'b0001);
      chk("rd1_rready", rready, 1);
      chk("rd1_data", {c_rdata, c_rlast, c_rresp}, {32'hDEAD_BEEF, 1'b1, 2'b00});
      nxt();
      // back in idle: rvalid still high must not reach clients
      #1 chk("rd1_idle_c_rvalid", c_rvalid, 0);
      chk("rd1_idle_rready", rready, 0);
      rvalid = 0; rlast = 0; c_rready = '0;

      // fairness: ports 0,1 each want 4 reads; last grant was 0 so 1 goes first
      cnt0 = 4; cnt1 = 4;
      c_arvalid = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         exp_g = (k % 2 == 0) ? 1 : 0;
         nxt();
         chk("fair_arid", arid, exp_g);
         arready = 1;
         #1 chk("fair_c_arready", c_arready, 4'b1 << exp_g);
         nxt();
         arready = 0;
         rvalid = 1; rlast = 1; rid = 4'(exp_g); c_rready = 4'b0011;
         #1 chk("fair_c_rvalid", c_rvalid, 4'b1 << exp_g);
         nxt();
         rvalid = 0; rlast = 0; c_rready = '0;
         if (exp_g == 0) cnt0--; else cnt1--;
         if (cnt0 == 0) c_arvalid[0] = 0;
         if (cnt1 == 0) c_arvalid[1] = 0;
      end
      chk("fair_idle", arvalid, 0);

      // read burst with rresp passthrough, then rid mismatch -> SLVERR
      c_arvalid = 4'b0001; c_arlen[7:0] = 8'd1;
      nxt();
      chk("err_arid", {arid, arlen}, {4'd0, 8'd1});
      arready = 1;
      nxt();
      arready = 0; c_arvalid = '0;
      rvalid = 1; rid = 0; rresp = 2'b01; rlast = 0; c_rready = 4'b0001;
      #1 chk("err_beat0_resp", {c_rresp, c_rlast}, {2'b01, 1'b0});
      nxt();
      rid = 4'd3; rresp = 2'b00; rlast = 1;
      #1 chk("err_beat1_c_rvalid", c_rvalid, 4'b0001);
      chk("err_rid_slverr", {c_rresp, c_rlast}, {2'b10, 1'b1});
      nxt();
      rvalid = 0; rlast = 0; rid = 0; c_rready = '0;

      // burst write, port 1, awlen=3, one wready stall
      c_awvalid = 4'b0010; c_awaddr[63:32] = 32'h0000_1000; c_awlen[15:8] = 8'd3; c_awsize[5:3] = 3'd2;
      nxt();
      chk("wr_aw", {awvalid, awid, awlen, awaddr}, {1'b1, 4'd1, 8'd3, 32'h0000_1000});
      chk("wr_awburst", awburst, 2'b01);
      awready = 1;
      #1 chk("wr_c_awready", c_awready, 4'b0010);
      nxt();
      awready = 0; c_awvalid = '0;
      c_wvalid = 4'b0010; c_wstrb[7:4] = 4'hF; wready = 0;
      c_wdata[63:32] = 32'hA0;
      #1 chk("wr_stall_c_wready", c_wready, 0);
      chk("wr_stall_wlast", wlast, 0);
      nxt();
      wready = 1;
      for (int b = 0; b < 4; b++) begin
         c_wdata[63:32] = 32'hA0 + b;
         #1;
         chk("wr_wvalid", wvalid, 1);
         chk("wr_wdata", {wdata, wstrb}, {32'hA0 + b, 4'hF});
         chk("wr_wlast", wlast, (b == 3) ? 1 : 0);
         chk("wr_c_wready", c_wready, 4'b0010);
         nxt();
      end
      c_wvalid = '0; wready = 0;
      bvalid = 1; bid = 4'd1; bresp = 2'b00; c_bready = 4'b0010;
      #1 chk("wr_c_bvalid", c_bvalid, 4'b0010);
      chk("wr_bready", {bready, c_bresp}, {1'b1, 2'b00});
      chk("wr_no_wvalid_in_resp", wvalid, 0);
      nxt();
      #1 chk("wr_idle_bready", {bready, c_bvalid}, 0);
      bvalid = 0; c_bready = '0;

      // concurrent read (port 0) and single-beat write (port 1)
      c_arvalid = 4'b0001; c_araddr[31:0] = 32'h0000_2000; c_arlen[7:0] = 0;
      c_awvalid = 4'b0010; c_awlen[15:8] = 8'd0;
      #1 chk("cc_none_yet", {arvalid, awvalid}, 0);
      nxt();
      chk("cc_both_valid", {arvalid, awvalid}, 2'b11);
      chk("cc_ids", {arid, awid}, {4'd0, 4'd1});
      arready = 1; awready = 1;
      #1 chk("cc_readies", {c_arready, c_awready}, {4'b0001, 4'b0010});
      nxt();
      arready = 0; awready = 0; c_arvalid = '0; c_awvalid = '0;
      rvalid = 1; rlast = 1; rid = 0; c_rready = 4'b0001;
      c_wvalid = 4'b0010; c_wdata[63:32] = 32'h5555_AAAA; wready = 1;
      #1 chk("cc_c_rvalid", c_rvalid, 4'b0001);
      chk("cc_w_single", {wvalid, wlast, wdata}, {1'b1, 1'b1, 32'h5555_AAAA});
      nxt();
      rvalid = 0; rlast = 0; c_rready = '0; c_wvalid = '0; wready = 0;
      bvalid = 1; bid = 4'd2; c_bready = 4'b0010;
      #1 chk("cc_bid_slverr", {c_bvalid, c_bresp}, {4'b0010, 2'b10});
      nxt();
      bvalid = 0; bid = 0; c_bready = '0;

      // rr with 4 ports: grant port 1 to set ptr=1, then 1 and 3 compete
      c_arvalid = 4'b0010;
      nxt();
      chk("rr4_setup_arid", arid, 1);
      arready = 1; nxt(); arready = 0;
      rvalid = 1; rlast = 1; rid = 1; c_rready = 4'b1010; nxt();
      rvalid = 0; rlast = 0;
      c_arvalid = 4'b1010;
      nxt();
      chk("rr4_first_port3", arid, 3);
      arready = 1; nxt(); arready = 0;
      rvalid = 1; rlast = 1; rid = 3; nxt();
      rvalid = 0; rlast = 0;
      nxt();
      chk("rr4_then_port1", arid, 1);
      // dropping the request after grant must not abort it
      c_arvalid = '0;
      #1 chk("rr4_hold_arvalid", arvalid, 1);
      arready = 1; nxt(); arready = 0;
      rvalid = 1; rlast = 1; rid = 1; nxt();
      rvalid = 0; rlast = 0; c_rready = '0;

      // reset in the middle of a write burst
      c_awvalid = 4'b0001; c_awlen[7:0] = 8'd2;
      nxt();
      chk("rs_awid", {awvalid, awid}, {1'b1, 4'd0});
      awready = 1; nxt(); awready = 0; c_awvalid = '0;
      c_wvalid = 4'b0001; wready = 1;
      nxt();
      #1 chk("rs_mid_burst", {wvalid, wlast}, {1'b1, 1'b0});
      rstn = 1'b0;
      #1 chk("rs_async_wvalid", wvalid, 0);
      chk("rs_async_c_wready", c_wready, 0);
      nxt();
      chk("rs_held_awvalid", awvalid, 0);
      // ports 0 and 1 request both paths; pointers reset so port 0 wins
      c_arvalid = 4'b0011; c_awvalid = 4'b0011;
      rstn = 1'b1;
      #1 chk("rs_release_idle", {arvalid, awvalid}, 0);
      nxt();
      chk("rs_first_grant", {arvalid, arid, awvalid, awid}, {1'b1, 4'd0, 1'b1, 4'd0});
      chk("rs_wvalid_not_data", wvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
